// File: rtl/hdmi_to_blocks.sv
// Raster HDMI stream to 8x8 block-major reorder through ping-pong strip buffers.
// Optional line-length check: define HDMI_TO_BLOCKS_SYNC_CHECK_EN.
module hdmi_to_blocks #(
    parameter int N     = 2,
    parameter int X_RES = 2160,
    parameter int Y_RES = 1200
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hdmi_v_sync,
    input  logic                    hdmi_h_sync,
    input  logic                    hdmi_data_valid,
    input  logic signed [N-1:0][7:0] hdmi_data_y,
    input  logic signed [N-1:0][7:0] hdmi_data_cr,
    input  logic signed [N-1:0][7:0] hdmi_data_cb,
    output logic                    blk_valid,
    output logic signed [N-1:0][7:0] blk_data_y,
    output logic signed [N-1:0][7:0] blk_data_cr,
    output logic signed [N-1:0][7:0] blk_data_cb,
    output logic                    blk_sob,
    output logic                    blk_eob,
    output logic                    blk_sof,
    output logic                    sync_err
);

    localparam int LINE_BEATS = X_RES / N;
    localparam int BUF_DEPTH  = 8 * LINE_BEATS;
    localparam int EB         = 8 / N;
    localparam int BLKS       = X_RES / 8;
    localparam int STRIPS     = Y_RES / 8;
    localparam int DW         = 24 * N;
    localparam int AW         = $clog2(BUF_DEPTH);
    localparam int CW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int EW = (EB > 1) ? $clog2(EB) : 1;
    localparam int BW = (BLKS > 1) ? $clog2(BLKS) : 1;
    localparam int SW = (STRIPS > 1) ? $clog2(STRIPS) : 1;

    typedef enum logic [1:0] {
        W_WAIT_VS,
        W_ACTIVE,
        W_DONE
    } wst_t;

    typedef enum logic {
        R_IDLE,
        R_READ
    } rdst_t;

    wst_t  r_wst, w_wst_nxt;
    rdst_t r_rd_st, w_rd_nxt;

    logic          r_vs_d;
    logic          w_vs_rise;
    logic          w_vs_fall;
    logic [CW-1:0] r_col;
    logic [2:0]    r_line;
    logic [SW-1:0] r_strip;
    logic          r_wsel;
    logic [1:0]    r_full;
    logic [1:0]    r_first;
    logic          w_wr;
    logic          w_line_end;
    logic          w_strip_end;
    logic          w_last_strip;
    logic [1:0]    w_set;
    logic [1:0]    w_clr;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    assign w_vs_rise    = hdmi_v_sync & ~r_vs_d;
    assign w_vs_fall    = ~hdmi_v_sync & r_vs_d;
    assign w_wr         = (r_wst == W_ACTIVE) & hdmi_data_valid & ~w_vs_rise;
    assign w_line_end   = (r_col == CW'(LINE_BEATS - 1));
    assign w_strip_end  = w_wr & w_line_end & (r_line == 3'd7);
    assign w_last_strip = (r_strip == SW'(STRIPS - 1));
    assign w_set        = w_strip_end ? (2'b01 << r_wsel) : 2'b00;
    assign w_waddr      = AW'(int'(r_line) * LINE_BEATS + int'(r_col));
    assign w_wdata      = {hdmi_data_cb, hdmi_data_cr, hdmi_data_y};

    always_comb begin
        w_wst_nxt = r_wst;
        unique case (r_wst)
            W_WAIT_VS: if (w_vs_fall) w_wst_nxt = W_ACTIVE;
            W_ACTIVE: begin
                if (w_vs_rise)
                    w_wst_nxt = W_WAIT_VS;
                else if (w_strip_end && w_last_strip)
                    w_wst_nxt = W_DONE;
            end
            W_DONE:    if (w_vs_rise) w_wst_nxt = W_WAIT_VS;
            default:   w_wst_nxt = W_WAIT_VS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wst   <= W_WAIT_VS;
            r_vs_d  <= 1'b0;
            r_col   <= '0;
            r_line  <= '0;
            r_strip <= '0;
            r_wsel  <= 1'b0;
            r_first <= '0;
        end else begin
            r_wst  <= w_wst_nxt;
            r_vs_d <= hdmi_v_sync;
            if (r_wst != W_ACTIVE) begin
                r_col   <= '0;
                r_line  <= '0;
                r_strip <= '0;
            end else if (w_wr) begin
                if (w_line_end) begin
                    r_col  <= '0;
                    r_line <= r_line + 3'd1;
                    if (r_line == 3'd7)
                        r_strip <= r_strip + SW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            // Tag each completed buffer so the reader knows where sof belongs
            if (w_strip_end) begin
                r_wsel          <= ~r_wsel;
                r_first[r_wsel] <= (r_strip == '0);
            end
        end
    end

    logic [BW-1:0] r_b;
    logic [2:0]    r_r;
    logic [EW-1:0] r_e;
    logic          r_rsel;
    logic          w_rd;
    logic          w_e_end;
    logic          w_r_end;
    logic          w_b_end;
    logic          w_rd_done;
    logic [AW-1:0] w_raddr;

    assign w_rd      = (r_rd_st == R_READ);
    assign w_e_end   = (r_e == EW'(EB - 1));
    assign w_r_end   = (r_r == 3'd7);
    assign w_b_end   = (r_b == BW'(BLKS - 1));
    assign w_rd_done = w_rd & w_e_end & w_r_end & w_b_end;
    assign w_clr     = w_rd_done ? (2'b01 << r_rsel) : 2'b00;
    assign w_raddr   = AW'(int'(r_r) * LINE_BEATS + int'(r_b) * EB + int'(r_e));

    always_comb begin
        w_rd_nxt = r_rd_st;
        unique case (r_rd_st)
            R_IDLE: if (|r_full) w_rd_nxt = R_READ;
            R_READ: if (w_rd_done && !r_full[~r_rsel]) w_rd_nxt = R_IDLE;
            default: w_rd_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_st <= R_IDLE;
            r_rsel  <= 1'b0;
            r_b     <= '0;
            r_r     <= '0;
            r_e     <= '0;
            r_full  <= '0;
        end else begin
            r_rd_st <= w_rd_nxt;
            r_full  <= (r_full & ~w_clr) | w_set;
            if (!w_rd) begin
                r_b <= '0;
                r_r <= '0;
                r_e <= '0;
                if (|r_full)
                    r_rsel <= r_full[r_rsel] ? r_rsel : ~r_rsel;
            end else if (w_e_end) begin
                r_e <= '0;
                if (w_r_end) begin
                    r_r <= '0;
                    r_b <= w_b_end ? '0 : r_b + BW'(1);
                end else begin
                    r_r <= r_r + 3'd1;
                end
                if (w_rd_done)
                    r_rsel <= ~r_rsel;
            end else begin
                r_e <= r_e + EW'(1);
            end
        end
    end

    logic [DW-1:0] r_mem [2*BUF_DEPTH];
    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[{r_wsel, w_waddr}] <= w_wdata;
        if (w_rd)
            r_q <= r_mem[{r_rsel, w_raddr}];
    end

    logic r_v1;
    logic r_sob1;
    logic r_eob1;
    logic r_sof1;
    logic w_sob;

    assign w_sob = w_rd & (r_r == 3'd0) & (r_e == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_sob1      <= 1'b0;
            r_eob1      <= 1'b0;
            r_sof1      <= 1'b0;
            blk_valid   <= 1'b0;
            blk_sob     <= 1'b0;
            blk_eob     <= 1'b0;
            blk_sof     <= 1'b0;
            blk_data_y  <= '0;
            blk_data_cr <= '0;
            blk_data_cb <= '0;
        end else begin
            r_v1        <= w_rd;
            r_sob1      <= w_sob;
            r_eob1      <= w_rd & w_r_end & w_e_end;
            r_sof1      <= w_sob & (r_b == '0) & r_first[r_rsel];
            blk_valid   <= r_v1;
            blk_sob     <= r_sob1;
            blk_eob     <= r_eob1;
            blk_sof     <= r_sof1;
            blk_data_y  <= r_v1 ? r_q[8*N-1:0] : '0;
            blk_data_cr <= r_v1 ? r_q[16*N-1:8*N] : '0;
            blk_data_cb <= r_v1 ? r_q[24*N-1:16*N] : '0;
        end
    end

`ifdef HDMI_TO_BLOCKS_SYNC_CHECK_EN
    localparam int HW = $clog2(LINE_BEATS + 1) + 1;

    logic          r_hs_d;
    logic [HW-1:0] r_hcnt;
    logic          r_err;
    logic          w_hs_rise;

    assign w_hs_rise = hdmi_h_sync & ~r_hs_d;
    assign sync_err  = r_err;

    // A zero count means no beats since the last pulse, which is not an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_d <= 1'b0;
            r_hcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_hs_d <= hdmi_h_sync;
            if (r_wst != W_ACTIVE) begin
                r_hcnt <= '0;
            end else if (w_hs_rise) begin
                if (r_hcnt != HW'(LINE_BEATS) && r_hcnt != '0)
                    r_err <= 1'b1;
                r_hcnt <= HW'(hdmi_data_valid);
            end else if (hdmi_data_valid && !(&r_hcnt)) begin
                r_hcnt <= r_hcnt + HW'(1);
            end
        end
    end
`else
    logic w_unused_hs;

    assign w_unused_hs = hdmi_h_sync;
    assign sync_err    = 1'b0;
`endif

endmodule

// File: tb/tb_hdmi_to_blocks.sv
// Directed bench for hdmi_to_blocks with 16x16 frames, N=2.
// Output beats are captured into a queue and compared to a reorder model.
module tb_hdmi_to_blocks;

    localparam int N  = 2;
    localparam int XR = 16;
    localparam int YR = 16;

`ifdef HDMI_TO_BLOCKS_SYNC_CHECK_EN
    localparam longint EXP_ERR = 1;
`else
    localparam longint EXP_ERR = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic v_sync, h_sync, dv;
    logic signed [N-1:0][7:0] dy, dcr, dcb;
    logic signed [N-1:0][7:0] oy, ocr, ocb;
    logic ov, osob, oeob, osof, oerr;

    hdmi_to_blocks #(.N(N), .X_RES(XR), .Y_RES(YR)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hdmi_v_sync     (v_sync),
        .hdmi_h_sync     (h_sync),
        .hdmi_data_valid (dv),
        .hdmi_data_y     (dy),
        .hdmi_data_cr    (dcr),
        .hdmi_data_cb    (dcb),
        .blk_valid       (ov),
        .blk_data_y      (oy),
        .blk_data_cr     (ocr),
        .blk_data_cb     (ocb),
        .blk_sob         (osob),
        .blk_eob         (oeob),
        .blk_sof         (osof),
        .sync_err        (oerr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] d;
        bit          sob;
        bit          eob;
        bit          sof;
        int          cyc;
    } obs_t;

    typedef struct {
        int         idx;
        logic [7:0] y0;
        logic [7:0] y1;
        bit         sob;
        bit         eob;
        bit         sof;
    } vec_t;

    obs_t q[$];
    obs_t o_tmp;
    vec_t tv[7];
    int   stray = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_beat = 0;
    int   l7_beat = 0;

    always @(negedge clk) begin
        if (rst_n && ov) begin
            o_tmp.d   = {ocb, ocr, oy};
            o_tmp.sob = osob;
            o_tmp.eob = oeob;
            o_tmp.sof = osof;
            o_tmp.cyc = cyc;
            q.push_back(o_tmp);
        end else if (rst_n && (osob || oeob || osof)) begin
            stray++;
        end
    end

    task automatic chk(string nm, longint got, longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    function automatic logic [47:0] pw(int row, int col, int off);
        logic [7:0] a, b;
        a = 8'(row * 16 + col + off);
        b = 8'(row * 16 + col + 1 + off);
        return {~b, ~a, b ^ 8'hA5, a ^ 8'hA5, b, a};
    endfunction

    task automatic drive(bit vs, bit hs, bit v, logic [7:0] y0, logic [7:0] y1);
        @(posedge clk);
        #1;
        v_sync = vs;
        h_sync = hs;
        dv     = v;
        dy[0]  = y0;
        dy[1]  = y1;
        dcr[0] = y0 ^ 8'hA5;
        dcr[1] = y1 ^ 8'hA5;
        dcb[0] = ~y0;
        dcb[1] = ~y1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic send_line(int row, int nb, int off, int gap);
        for (int c = 0; c < nb; c++) begin
            drive(0, 0, 1, 8'(row * 16 + 2 * c + off), 8'(row * 16 + 2 * c + 1 + off));
            last_beat = cyc + 1;
        end
        if (gap > 0) begin
            drive(0, 1, 0, 8'h00, 8'h00);
            for (int g = 1; g < gap; g++) drive(0, 0, 0, 8'h00, 8'h00);
        end
    endtask

    task automatic vs_pulse();
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 8'hEE, 8'hEE);
        drive(0, 0, 1, 8'hEE, 8'hEE);
    endtask

    task automatic check_frame(int base, int nb, int off, string tag);
        for (int k = 0; k < nb; k++) begin
            int s, kk, b, r, e, i;
            logic [47:0] ed;
            bit es, ee, ef;
            s  = k / 64;
            kk = k % 64;
            b  = kk / 32;
            r  = (kk % 32) / 4;
            e  = kk % 4;
            ed = pw(8 * s + r, 8 * b + 2 * e, off);
            es = (r == 0 && e == 0);
            ee = (r == 7 && e == 3);
            ef = es && (s == 0) && (b == 0);
            i  = base + k;
            if (i < q.size()) begin
                checks++;
                if (q[i].d !== ed || q[i].sob != es || q[i].eob != ee || q[i].sof != ef) begin
                    errors++;
                    $display("FAIL %s beat %0d: got d=%h sob=%b eob=%b sof=%b, want d=%h sob=%b eob=%b sof=%b",
                             tag, k, q[i].d, q[i].sob, q[i].eob, q[i].sof, ed, es, ee, ef);
                end
            end
        end
    endtask

    initial begin
        tv[0] = '{0,   8'd0,   8'd1,   1, 0, 1};
        tv[1] = '{4,   8'd16,  8'd17,  0, 0, 0};
        tv[2] = '{31,  8'd118, 8'd119, 0, 1, 0};
        tv[3] = '{32,  8'd8,   8'd9,   1, 0, 0};
        tv[4] = '{63,  8'd126, 8'd127, 0, 1, 0};
        tv[5] = '{64,  8'd128, 8'd129, 1, 0, 0};
        tv[6] = '{127, 8'd254, 8'd255, 0, 1, 0};

        rst_n  = 1'b0;
        v_sync = 1'b0;
        h_sync = 1'b0;
        dv     = 1'b0;
        dy     = '0;
        dcr    = '0;
        dcb    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {ov, osob, oeob, osof, oerr, oy, ocr, ocb}, 0);
        rst_n = 1'b1;

        for (int r = 0; r < 8; r++) send_line(r, 8, 0, 0);
        idle(10);
        chk("no_out_before_vs", q.size(), 0);

        vs_pulse();
        for (int r = 0; r < 8; r++) send_line(r, 8, 0, 0);
        idle(10);
        chk("pre_rst_valid", ov, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {ov, osob, oeob, osof, oerr, oy, ocr, ocb}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        idle(5);
        chk("no_out_after_rst", q.size(), 0);

        vs_pulse();
        for (int r = 0; r < 16; r++) begin
            send_line(r, 8, 0, 2);
            if (r == 6) chk("no_out_7_lines", q.size(), 0);
            if (r == 7) l7_beat = last_beat;
        end
        idle(100);
        chk("t2_count", q.size(), 128);
        if (q.size() > 0) chk("t2_latency", q[0].cyc - l7_beat, 3);
        for (int i = 0; i < 7; i++) begin
            if (tv[i].idx < q.size()) begin
                chk($sformatf("t2_vec%0d_y", i), q[tv[i].idx].d[15:0], {tv[i].y1, tv[i].y0});
                chk($sformatf("t2_vec%0d_flags", i),
                    {q[tv[i].idx].sob, q[tv[i].idx].eob, q[tv[i].idx].sof},
                    {tv[i].sob, tv[i].eob, tv[i].sof});
            end
        end
        check_frame(0, 128, 0, "t2");
        if (q.size() >= 64) chk("t2_contig_strip0", q[63].cyc - q[0].cyc, 63);

        for (int r = 0; r < 16; r++) send_line(r, 8, 0, 2);
        idle(20);
        chk("t4_drop_after_frame", q.size(), 128);
        q.delete();

        vs_pulse();
        for (int r = 0; r < 16; r++) send_line(r, 8, 3, 0);
        vs_pulse();
        for (int r = 0; r < 16; r++) send_line(r, 8, 9, 0);
        idle(150);
        chk("t3_count", q.size(), 256);
        begin
            int nsof;
            nsof = 0;
            foreach (q[i]) if (q[i].sof) nsof++;
            chk("t3_sof_count", nsof, 2);
        end
        check_frame(0, 128, 3, "t3_f0");
        check_frame(128, 128, 9, "t3_f1");
        if (q.size() == 256) begin
            chk("t3_contig_f0", q[127].cyc - q[0].cyc, 127);
            chk("t3_contig_f1", q[255].cyc - q[128].cyc, 127);
        end
        q.delete();

        vs_pulse();
        for (int r = 0; r < 13; r++) send_line(r, 8, 40, 2);
        vs_pulse();
        for (int r = 0; r < 16; r++) send_line(r, 8, 0, 2);
        idle(100);
        chk("t5_count", q.size(), 192);
        check_frame(0, 64, 40, "t5_short");
        check_frame(64, 128, 0, "t5_next");
        if (q.size() > 64) begin
            chk("t5_next_sof", q[64].sof, 1);
            chk("t5_next_y", q[64].d[15:0], 16'h0100);
        end
        q.delete();

        chk("t6_err_clean", oerr, 0);
        vs_pulse();
        send_line(0, 8, 0, 2);
        send_line(1, 8, 0, 2);
        send_line(2, 7, 0, 2);
        send_line(3, 8, 0, 2);
        idle(2);
        chk("t6_err_set", oerr, EXP_ERR);
        vs_pulse();
        for (int r = 0; r < 16; r++) send_line(r, 8, 5, 2);
        idle(100);
        chk("t6_err_sticky", oerr, EXP_ERR);
        chk("t6_count", q.size(), 128);
        check_frame(0, 128, 5, "t6");

        chk("stray_flags", stray, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hdmi_to_blocks.md
Name: hdmi_to_blocks

Overview:
Upstream counterpart of the block-to-HDMI output stage. It accepts a raster-order HDMI pixel stream (N pixels/beat, YCrCb) and re-orders each 8-line strip into 8x8 blocks. Blocks leave in block-major order with sob/eob/sof framing, ready for the JPEG block pipeline. Strips are ping-ponged through two strip buffers so input never stalls.

Parameters:
N, 2, pixels per beat; must divide 8.
X_RES, 2160, active pixels per line; multiple of 8.
Y_RES, 1200, active lines per frame; multiple of 8.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
hdmi_v_sync  in  1  vertical sync; high during frame sync.
hdmi_h_sync  in  1  horizontal sync pulse; used only by the optional check.
hdmi_data_valid  in  1  active-pixel beat qualifier.
hdmi_data_y / hdmi_data_cr / hdmi_data_cb  in  signed [N-1:0][7:0] each  pixel components; element 0 is leftmost.
blk_valid  out  1  output beat valid.
blk_data_y / blk_data_cr / blk_data_cb  out  signed [N-1:0][7:0] each  block beat.
blk_sob  out  1  first beat of a block.
blk_eob  out  1  last beat of a block.
blk_sof  out  1  first beat of block 0 of strip 0 of a frame.
sync_err  out  1  sticky line-length error; see Optional Feature.

Behaviour:
- Reset: all outputs 0. Writer in W_WAIT_VS. Reader in R_IDLE. Buffer select = 0. Both full flags clear.
- Derived constants: LINE_BEATS = X_RES/N. BLK_BEATS = 64/N. BUF_DEPTH = 8*LINE_BEATS. Each strip buffer is BUF_DEPTH words of 24*N bits, packed {cb,cr,y}.
- Writer FSM:
  - W_WAIT_VS: all valid beats are ignored. Falling edge of hdmi_v_sync -> W_ACTIVE, with col, line and strip = 0.
  - W_ACTIVE: each valid beat writes address line_in_strip*LINE_BEATS + col. col wraps at LINE_BEATS-1 and advances line.
  - After line 7 of a strip: mark the current buffer full, toggle the write select, increment strip.
  - After strip Y_RES/8-1 completes -> W_DONE.
- W_DONE: valid beats are dropped. Rising edge of hdmi_v_sync -> W_WAIT_VS.
- hdmi_v_sync rising while in W_ACTIVE (short frame):
  - The partial strip is discarded; its buffer is not marked full.
  - Writer -> W_WAIT_VS.
  - A reader already in progress completes normally.
- Reader FSM:
  - R_IDLE: any full buffer -> R_READ on the next cycle, with b, r, e = 0.
  - R_READ: issues one read per cycle at address r*LINE_BEATS + b*(8/N) + e. e wraps at 8/N-1 and advances r; r wraps at 7 and advances b.
  - After b = X_RES/8-1, r = 7, e = 8/N-1: clear that buffer's full flag, toggle the read select. If the other buffer is full, stay in R_READ; otherwise go to R_IDLE.
  - The output is continuous: no gap between blocks or between strips.
- Timing and latency:
  - RAM read is registered (1 cycle); outputs are registered (1 cycle).
  - The first blk_valid of a strip appears exactly 3 cycles after the valid input beat that completed line 7.
  - Reading a strip takes BUF_DEPTH cycles, which is no more than the fill time of the next strip. This guarantees no overrun, so no backpressure exists.
- Framing flags (all 0 when blk_valid = 0):
  - blk_sob when r = 0 and e = 0.
  - blk_eob when r = 7 and e = 8/N-1.
  - blk_sof coincides with blk_sob of b = 0 in strip 0. Only one per frame.
- Data is passed through unmodified; no arithmetic or sign handling.
- A simultaneous buffer-full set (writer) and clear (reader) on different buffers in the same cycle are both honoured.

Optional Feature:
Macro HDMI_TO_BLOCKS_SYNC_CHECK_EN.
- Defined, in W_ACTIVE: each rising edge of hdmi_h_sync compares the valid beats counted since the previous rising edge against LINE_BEATS. If they differ and the count is nonzero, sync_err is set and held until reset. Block data flow is unaffected.
- Not defined: sync_err is tied to 0 and no check logic is built.

Test Plan:
Configuration for all tests: N=2, X_RES=16, Y_RES=16, so LINE_BEATS=8, BLK_BEATS=32, BUF_DEPTH=64.
1. Reset asserted mid-stream -> all outputs 0 the same cycle. After release, no blk_valid until a v_sync fall plus 8 full lines.
2. Ramp frame with y = row*16 + col:
   - First output beat: y = (0,1) with sob = 1 and sof = 1. Beat 5: y = (16,17).
   - Beat 32: y = (118,119) with eob = 1. Beat 33: y = (8,9) with sob = 1 and sof = 0.
3. Back-to-back valid input, no blanking, 2 frames -> exactly 8 blocks (256 valid beats). sof appears twice; data matches the reference reorder; no gaps within a strip pair.
4. Valid beats driven before the first v_sync fall, and after line 15 before the next v_sync -> no blk_valid produced from either.
5. v_sync rises after 5 lines of strip 1 -> strip 0 blocks are emitted complete; strip 1 data is never emitted; the next frame starts with sof = 1 and y = (0,1).
6. With HDMI_TO_BLOCKS_SYNC_CHECK_EN defined, one line of 7 beats between h_sync pulses -> sync_err = 1 and stays 1. With the macro undefined -> sync_err = 0.
